press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_pkg.sv | 20 ++
 rtl/edge_detect.sv | 19 +
 rtl/press_classifier.sv | 132 +++++++++++++
 tb/tb_press_classifier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared FSM state encoding, default timing constants and a small helper
// used to size the press/double-click counter.
package press_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_PRESS1 = 3'd1;
  localparam state_t S_LONG   = 3'd2;
  localparam state_t S_WAIT2  = 3'd3;
  localparam state_t S_PRESS2 = 3'd4;

  localparam int DEF_LONG_CYCLES   = 200;
  localparam int DEF_DCLICK_CYCLES = 50;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Delays the button level by one cycle and flags rising/falling edges.
// The delay register always follows the input, reset included, so a button held through reset shows no edge.
module edge_detect (
  input  logic i_clk,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic r_din_q;

  always_ff @(posedge i_clk) begin
    r_din_q <= i_din;
  end

  assign o_rise = i_din & ~r_din_q;
  assign o_fall = ~i_din & r_din_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button into press/release edges and short, long and double-click events.
// All outputs are registered: each pulse follows the clock edge that first sampled its cause.
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic db_in,
  input  logic en,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, DCLICK_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  logic             w_rise;
  logic             w_fall;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_short;
  logic             w_long;
  logic             w_dclick;
  logic             r_press;
  logic             r_release;
  logic             r_short;
  logic             r_long;
  logic             r_dclick;
  logic             r_held;

  edge_detect u_edge_detect (
    .i_clk  (clk),
    .i_din  (db_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // A release on the long threshold cycle and a second press on the
  // timeout cycle both take the edge branch, which is checked first.
  always_comb begin
    w_state_nxt = r_state;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_dclick    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (w_fall) begin
          w_state_nxt = S_WAIT2;
        end else if (db_in && (r_cnt >= LONG_LAST)) begin
          w_state_nxt = S_LONG;
          w_long      = 1'b1;
        end
      end
      S_LONG: begin
        if (w_fall) w_state_nxt = S_IDLE;
      end
      S_WAIT2: begin
        if (w_rise) begin
          w_state_nxt = S_PRESS2;
          w_dclick    = 1'b1;
        end else if (r_cnt >= DCLK_LAST) begin
          w_state_nxt = S_IDLE;
          w_short     = 1'b1;
        end
      end
      S_PRESS2: begin
        if (w_fall) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_dclick    = 1'b0;
    end
  end

  // The counter only runs while staying in a timed state; any transition clears it.
  always_comb begin
    w_cnt_nxt = '0;
    if ((w_state_nxt == r_state) && ((r_state == S_PRESS1) || (r_state == S_WAIT2))) begin
      w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_dclick  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= en & w_rise;
      r_release <= en & w_fall;
      r_short   <= w_short;
      r_long    <= w_long;
      r_dclick  <= w_dclick;
      r_held    <= en & (w_state_nxt == S_LONG);
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_press   = r_short;
  assign long_press    = r_long;
  assign double_click  = r_dclick;
  assign held          = r_held;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench: stimulus queues expected pulse events; a negedge monitor matches them against the outputs.
module tb_press_classifier;

  localparam int LONG_C = 20;
  localparam int DCLK_C = 10;
  localparam int BIG    = 1 << 30;

  localparam logic [4:0] P  = 5'b00001;
  localparam logic [4:0] R  = 5'b00010;
  localparam logic [4:0] SH = 5'b00100;
  localparam logic [4:0] LG = 5'b01000;
  localparam logic [4:0] DC = 5'b10000;

  logic clk = 1'b0;
  logic rst;
  logic db_in;
  logic en;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic held;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc     = 0;
  int         checks  = 0;
  int         errors  = 0;
  int         held_lo = 0;
  int         held_hi = 0;
  logic       mon_on  = 1'b0;
  logic [4:0] mv;
  logic       exp_h;

  press_classifier #(
    .LONG_CYCLES   (LONG_C),
    .DCLICK_CYCLES (DCLK_C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .db_in         (db_in),
    .en            (en),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .double_click  (double_click),
    .held          (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Event vector bits: {double_click, long_press, short_press, release_pulse, press_pulse}
  always @(negedge clk) begin
    if (mon_on) begin
      mv = {double_click, long_press, short_press, release_pulse, press_pulse};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: expected %b at cycle %0d, seen nothing", exp_q[0].v, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (mv !== 5'b0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].v !== mv) begin
          errors++;
          $display("FAIL event_match: got %b at cycle %0d, expected %b at cycle %0d",
                   mv, cyc, (exp_q.size() > 0) ? exp_q[0].v : 5'b0,
                   (exp_q.size() > 0) ? exp_q[0].cyc : -1);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) void'(exp_q.pop_front());
        checks++;
        if ($countones(mv[4:2]) > 1) begin
          errors++;
          $display("FAIL class_onehot: got %b at cycle %0d, expected at most one class bit", mv, cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: expected %b at cycle %0d, got 00000", exp_q[0].v, cyc);
        void'(exp_q.pop_front());
      end
      exp_h = (cyc >= held_lo) && (cyc < held_hi);
      checks++;
      if (held !== exp_h) begin
        errors++;
        $display("FAIL held_level: got %b at cycle %0d, expected %b", held, cyc, exp_h);
      end
    end
  end

  initial begin
    int s;
    int f;
    rst   = 1'b1;
    en    = 1'b1;
    db_in = 1'b0;
    wait_cyc(3);
    chk("rst_press",   int'(press_pulse),   0);
    chk("rst_release", int'(release_pulse), 0);
    chk("rst_short",   int'(short_press),   0);
    chk("rst_long",    int'(long_press),    0);
    chk("rst_dclick",  int'(double_click),  0);
    chk("rst_held",    int'(held),          0);
    rst    = 1'b0;
    mon_on = 1'b1;
    wait_cyc(3);

    // Short press: high 5, low 15
    db_in = 1'b1; s = cyc + 1; push(s, P);
    wait_cyc(5);
    db_in = 1'b0; f = cyc + 1; push(f, R); push(f + DCLK_C, SH);
    wait_cyc(20);

    // Long press: high 30
    db_in = 1'b1; s = cyc + 1; push(s, P); push(s + LONG_C, LG);
    held_lo = s + LONG_C; held_hi = BIG;
    wait_cyc(30);
    db_in = 1'b0; f = cyc + 1; push(f, R); held_hi = f;
    wait_cyc(20);

    // Long press released one cycle after the threshold
    db_in = 1'b1; s = cyc + 1; push(s, P); push(s + LONG_C, LG);
    held_lo = s + LONG_C; held_hi = BIG;
    wait_cyc(LONG_C + 1);
    db_in = 1'b0; f = cyc + 1; push(f, R); held_hi = f;
    wait_cyc(20);

    // Double click: high 5, low 4, high 5
    db_in = 1'b1; s = cyc + 1; push(s, P);
    wait_cyc(5);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(4);
    db_in = 1'b1; s = cyc + 1; push(s, P | DC);
    wait_cyc(5);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(20);

    // Boundaries: release on the long threshold cycle, second rise on the timeout cycle
    db_in = 1'b1; s = cyc + 1; push(s, P);
    wait_cyc(LONG_C);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(DCLK_C);
    db_in = 1'b1; s = cyc + 1; push(s, P | DC);
    wait_cyc(5);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(20);

    // Button held through reset
    db_in = 1'b1; rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(30);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(5);

    // Reset eight cycles into a press aborts it
    db_in = 1'b1; s = cyc + 1; push(s, P);
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(25);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(20);

    // Enable dropped during a 30+ cycle press, restored while still pressed
    db_in = 1'b1; s = cyc + 1; push(s, P);
    wait_cyc(5);
    en = 1'b0;
    wait_cyc(25);
    en = 1'b1;
    wait_cyc(10);
    db_in = 1'b0; f = cyc + 1; push(f, R);
    wait_cyc(20);

    // Release while disabled produces nothing
    db_in = 1'b1; s = cyc + 1; push(s, P);
    wait_cyc(3);
    en = 1'b0;
    wait_cyc(2);
    db_in = 1'b0;
    wait_cyc(3);
    en = 1'b1;
    wait_cyc(15);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
